// File: rtl/pipe_semaphore_arbiter.sv
// rtl/pipe_semaphore_arbiter.sv - round-robin key semaphore sharing one pipeline write port
module pipe_semaphore_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         rel,
  input  logic [NUM_REQ-1:0]         wr_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wr_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         wr_ready,
  output logic                       pipe_valid,
  output logic [ADDR_W-1:0]          pipe_addr,
  output logic [DATA_W-1:0]          pipe_data,
  output logic [CNT_W-1:0]           count,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [BW-1:0]   beat_cnt;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic            accept;
  logic            burst_done;

  // First requester at or after rr_ptr, wrapping around the ring.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!pick_found && req[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IW'(k) == owner) begin
        sel_addr = wr_addr[k*ADDR_W +: ADDR_W];
        sel_data = wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_ready   = (state == OWNED) ? gnt : '0;
  assign accept     = (state == OWNED) && wr_valid[owner];
  assign burst_done = (MAX_BURST != 0) && ((beat_cnt + BW'(1)) == BW'(MAX_BURST));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      pipe_valid <= 1'b0;
      pipe_addr  <= '0;
      pipe_data  <= '0;
      count      <= '0;
    end else begin
      pipe_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt      <= NUM_REQ'(1) << pick_idx;
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= OWNED;
          end
        end
        OWNED: begin
          if (accept) begin
            pipe_valid <= 1'b1;
            pipe_addr  <= sel_addr;
            pipe_data  <= sel_data;
            count      <= count + CNT_W'(1);
            beat_cnt   <= beat_cnt + BW'(1);
          end
          // A beat arriving with the release is still taken before the key goes back.
          if (rel[owner] || (accept && burst_done)) begin
            gnt   <= '0;
            state <= TURN;
          end
        end
        TURN: begin
          rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
          state  <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_semaphore_arbiter.sv
// tb/tb_pipe_semaphore_arbiter.sv - directed scoreboard bench for pipe_semaphore_arbiter
module tb_pipe_semaphore_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, rel, wr_valid;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  gnt, wr_ready;
  logic        pipe_valid;
  logic [7:0]  pipe_addr, pipe_data, count;
  logic        busy;
  logic [3:0]  gnt4, wr_ready4;
  logic        pipe_valid4;
  logic [7:0]  pipe_addr4, pipe_data4;
  logic [3:0]  count4;
  logic        busy4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } beat_t;

  beat_t       sb[$];
  int          passes = 0;
  int          total  = 0;
  logic [31:0] exp_count;

  always #5 clk = ~clk;

  pipe_semaphore_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt), .wr_ready(wr_ready),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .count(count), .busy(busy)
  );

  pipe_semaphore_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt4), .wr_ready(wr_ready4),
    .pipe_valid(pipe_valid4), .pipe_addr(pipe_addr4), .pipe_data(pipe_data4),
    .count(count4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and compare registered outputs against the scoreboard.
  task automatic tick();
    beat_t b;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      b = sb.pop_front();
      chk("pipe_valid", {31'd0, pipe_valid}, 32'd1);
      chk("pipe_addr", {24'd0, pipe_addr}, {24'd0, b.a});
      chk("pipe_data", {24'd0, pipe_data}, {24'd0, b.d});
    end else begin
      chk("pipe_idle", {31'd0, pipe_valid}, 32'd0);
    end
    chk("count", {24'd0, count}, exp_count & 32'hFF);
    chk("count4", {28'd0, count4}, exp_count & 32'hF);
    chk("gnt_onehot", {31'd0, $onehot0(gnt)}, 32'd1);
    chk("ready_in_gnt", {28'd0, wr_ready & ~gnt}, 32'd0);
  endtask

  task automatic set_beat(input int i, input logic [7:0] a, input logic [7:0] d);
    wr_valid = '0;
    wr_valid[i] = 1'b1;
    wr_addr[i*8 +: 8] = a;
    wr_data[i*8 +: 8] = d;
  endtask

  task automatic accept_beat(input int i, input logic [7:0] a, input logic [7:0] d);
    beat_t b;
    set_beat(i, a, d);
    chk("wr_ready_owner", {31'd0, wr_ready[i]}, 32'd1);
    b.a = a;
    b.d = d;
    sb.push_back(b);
    exp_count++;
    tick();
    wr_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rel = '0;
    wr_valid = '0;
    sb.delete();
    exp_count = 0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int order3[5];
    int order4[3];
    order3 = '{0, 1, 2, 3, 0};
    order4 = '{0, 1, 2};
    wr_addr = '0;
    wr_data = '0;

    // Reset held two cycles
    do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single owner, three beats then release
    req = 4'b0010;
    tick();
    chk("t2_gnt", {28'd0, gnt}, 32'b0010);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 3; k++) accept_beat(1, 8'(k), 8'hA0 + 8'(k));
    rel = 4'b0010;
    req = '0;
    tick();
    rel = '0;
    chk("t2_turn_gnt", {28'd0, gnt}, 32'd0);
    chk("t2_turn_busy", {31'd0, busy}, 32'd1);
    chk("t2_turn_ready", {28'd0, wr_ready}, 32'd0);
    tick();
    chk("t2_idle_busy", {31'd0, busy}, 32'd0);
    chk("t2_count", {24'd0, count}, 32'd3);

    // Round robin with all requesting
    do_reset();
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t3_gnt", {28'd0, gnt}, 32'd1 << order3[n]);
      accept_beat(order3[n], 8'h30 + 8'(order3[n]), 8'hC0 + 8'(n));
      rel = 4'(1 << order3[n]);
      tick();
      rel = '0;
      chk("t3_turn_gnt", {28'd0, gnt}, 32'd0);
      tick();
    end
    req = '0;
    tick();

    // Forced release after MAX_BURST beats
    do_reset();
    req = 4'b0100;
    tick();
    chk("t4_gnt", {28'd0, gnt}, 32'b0100);
    req = 4'hF;
    for (int k = 0; k < 4; k++) accept_beat(2, 8'h40 + 8'(k), 8'hD0 + 8'(k));
    set_beat(2, 8'h44, 8'hD4);
    chk("t4_ready_drop", {28'd0, wr_ready}, 32'd0);
    tick();
    chk("t4_turn_gnt", {28'd0, gnt}, 32'd0);
    tick();
    chk("t4_next_gnt", {28'd0, gnt}, 32'b1000);
    chk("t4_no_ready2", {31'd0, wr_ready[2]}, 32'd0);
    wr_valid = '0;
    chk("t4_count", {24'd0, count}, 32'd4);
    for (int n = 0; n < 3; n++) begin
      rel = gnt;
      tick();
      rel = '0;
      tick();
      tick();
      chk("t4_rr_gnt", {28'd0, gnt}, 32'd1 << order4[n]);
    end
    rel = 4'b0100;
    req = '0;
    tick();
    rel = '0;
    tick();

    // Simultaneous release and beat, non-owner release ignored
    do_reset();
    req = 4'b0001;
    tick();
    chk("t5_gnt", {28'd0, gnt}, 32'b0001);
    rel = 4'b1000;
    tick();
    rel = '0;
    chk("t5_nonowner_rel", {28'd0, gnt}, 32'b0001);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    rel = 4'b0001;
    req = '0;
    accept_beat(0, 8'h55, 8'h5A);
    rel = '0;
    chk("t5_gnt_after", {28'd0, gnt}, 32'd0);
    tick();
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a burst
    req = 4'b0100;
    tick();
    chk("t6_gnt", {28'd0, gnt}, 32'b0100);
    accept_beat(2, 8'h66, 8'h6B);
    set_beat(2, 8'h77, 8'h7C);
    rst = 1'b1;
    exp_count = 0;
    tick();
    rst = 1'b0;
    wr_valid = '0;
    chk("t6_gnt_rst", {28'd0, gnt}, 32'd0);
    chk("t6_busy_rst", {31'd0, busy}, 32'd0);
    req = 4'b0101;
    tick();
    chk("t6_gnt_after", {28'd0, gnt}, 32'b0001);
    rel = 4'b0001;
    req = '0;
    tick();
    rel = '0;
    tick();

    // Counter wrap on the 4-bit instance after 16 beats
    do_reset();
    req = 4'b0001;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("t7_gnt", {28'd0, gnt}, 32'b0001);
      for (int k = 0; k < 4; k++) accept_beat(0, 8'(b*4 + k), 8'hE0 + 8'(b*4 + k));
      tick();
    end
    req = '0;
    chk("t7_count16", {24'd0, count}, 32'd16);
    chk("t7_count4_wrap", {28'd0, count4}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
